// File: rtl/io_handshake_unit_pkg.sv
// Shared definitions for the IO handshake unit: byte width, FIFO depth
// default and the state encodings of the input and output paths.
package io_handshake_unit_pkg;

  localparam int BYTE_W             = 8;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Input path: INPR empty (fgi=0) or holding an unread byte (fgi=1)
  typedef enum logic {
    IN_EMPTY = 1'b0,
    IN_FULL  = 1'b1
  } in_state_t;

  // Output path: device free (fgo=1) or a byte offered to the device
  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_SEND = 1'b1
  } out_state_t;

  // Count register width: must represent 0..depth inclusive
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO for the device input path. Pushes when full and pops when
// empty are dropped internally, so callers may drive push/pop freely.
module io_byte_fifo
  import io_handshake_unit_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic              myclock,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  // Head is read straight from the array; the consumer registers it
  assign pop_data = mem[rd_ptr_reg];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge myclock) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally
  always_ff @(posedge myclock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/io_handshake_unit.sv
// Programmed-IO handshake unit: buffers device input bytes into INPR with
// the FGI flag, hands OUTR bytes to the device with the FGO flag, and
// raises the interrupt request when enabled and either flag is set.
module io_handshake_unit
  import io_handshake_unit_pkg::*;
#(
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int CNT_W      = fifo_cnt_w(FIFO_DEPTH)
) (
  input  logic              myclock,
  input  logic              reset,
  input  logic              dev_in_valid,
  input  logic [BYTE_W-1:0] dev_in_data,
  output logic              dev_in_ready,
  output logic [BYTE_W-1:0] inpr_data,
  output logic              fgi,
  input  logic              inp_ack,
  input  logic [BYTE_W-1:0] outr_data,
  input  logic              out_strobe,
  output logic              fgo,
  output logic              dev_out_valid,
  output logic [BYTE_W-1:0] dev_out_data,
  input  logic              dev_out_ready,
  input  logic              ien,
  output logic              int_req,
  output logic              out_overrun
);

  in_state_t         in_state_reg, in_state_next;
  out_state_t        out_state_reg, out_state_next;
  logic [BYTE_W-1:0] inpr_data_reg;
  logic [BYTE_W-1:0] dev_out_data_reg;
  logic              overrun_reg;

  logic              fifo_push;
  logic              fifo_pop;
  logic [BYTE_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // Pop only when INPR is free (registered state), so at most one byte
  // reaches INPR every two cycles.
  assign fifo_pop     = (in_state_reg == IN_EMPTY) && !fifo_empty;
  assign fifo_push    = dev_in_valid && !fifo_full;
  assign dev_in_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

  io_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .myclock   (myclock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (dev_in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State registers for both paths
  always_ff @(posedge myclock or posedge reset) begin
    if (reset) begin
      in_state_reg  <= IN_EMPTY;
      out_state_reg <= OUT_IDLE;
    end else begin
      in_state_reg  <= in_state_next;
      out_state_reg <= out_state_next;
    end
  end

  // Data registers: INPR loads on pop, device byte loads on accepted strobe,
  // overrun is sticky until reset
  always_ff @(posedge myclock or posedge reset) begin
    if (reset) begin
      inpr_data_reg    <= '0;
      dev_out_data_reg <= '0;
      overrun_reg      <= 1'b0;
    end else begin
      if (fifo_pop) inpr_data_reg <= fifo_head;
      if (out_state_reg == OUT_IDLE && out_strobe) dev_out_data_reg <= outr_data;
      if (out_state_reg == OUT_SEND && out_strobe) overrun_reg <= 1'b1;
    end
  end

  // Next-state logic for the input and output paths
  always_comb begin
    in_state_next  = in_state_reg;
    out_state_next = out_state_reg;
    case (in_state_reg)
      IN_EMPTY: if (!fifo_empty) in_state_next = IN_FULL;
      IN_FULL:  if (inp_ack)     in_state_next = IN_EMPTY;
      default:                   in_state_next = IN_EMPTY;
    endcase
    case (out_state_reg)
      OUT_IDLE: if (out_strobe)    out_state_next = OUT_SEND;
      OUT_SEND: if (dev_out_ready) out_state_next = OUT_IDLE;
      default:                     out_state_next = OUT_IDLE;
    endcase
  end

  // Moore outputs decoded from the state registers
  always_comb begin
    fgi           = (in_state_reg == IN_FULL);
    fgo           = (out_state_reg == OUT_IDLE);
    dev_out_valid = (out_state_reg == OUT_SEND);
    inpr_data     = inpr_data_reg;
    dev_out_data  = dev_out_data_reg;
    out_overrun   = overrun_reg;
    int_req       = ien && ((in_state_reg == IN_FULL) || (out_state_reg == OUT_IDLE));
  end

endmodule

// File: tb/tb_io_handshake_unit.sv
// Bench for io_handshake_unit: a table of directed cycles, hand-written
// FIFO-fill and async-reset sequences, then random traffic against a
// queue-based reference model.
module tb_io_handshake_unit;

  localparam int DEPTH = 4;

  logic       myclock;
  logic       reset;
  logic       dev_in_valid;
  logic [7:0] dev_in_data;
  logic       dev_in_ready;
  logic [7:0] inpr_data;
  logic       fgi;
  logic       inp_ack;
  logic [7:0] outr_data;
  logic       out_strobe;
  logic       fgo;
  logic       dev_out_valid;
  logic [7:0] dev_out_data;
  logic       dev_out_ready;
  logic       ien;
  logic       int_req;
  logic       out_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  io_handshake_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .myclock       (myclock),
    .reset         (reset),
    .dev_in_valid  (dev_in_valid),
    .dev_in_data   (dev_in_data),
    .dev_in_ready  (dev_in_ready),
    .inpr_data     (inpr_data),
    .fgi           (fgi),
    .inp_ack       (inp_ack),
    .outr_data     (outr_data),
    .out_strobe    (out_strobe),
    .fgo           (fgo),
    .dev_out_valid (dev_out_valid),
    .dev_out_data  (dev_out_data),
    .dev_out_ready (dev_out_ready),
    .ien           (ien),
    .int_req       (int_req),
    .out_overrun   (out_overrun)
  );

  initial myclock = 1'b0;
  always #5 myclock = ~myclock;

  typedef struct {
    logic       div;
    logic [7:0] did;
    logic       ack;
    logic       stb;
    logic [7:0] outr;
    logic       rdy;
    logic       ie;
    logic       e_fgi;
    logic [7:0] e_inpr;
    logic       e_dir;
    logic       e_fgo;
    logic       e_dov;
    logic [7:0] e_dod;
    logic       e_ovr;
    logic       e_int;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output; device data is only meaningful while offered
  task automatic chk_all(input string tag, input logic e_fgi, input logic [7:0] e_inpr,
                         input logic e_dir, input logic e_fgo, input logic e_dov,
                         input logic [7:0] e_dod, input logic e_ovr, input logic e_int);
    chk({tag, " fgi"}, 8'(fgi), 8'(e_fgi));
    chk({tag, " inpr_data"}, inpr_data, e_inpr);
    chk({tag, " dev_in_ready"}, 8'(dev_in_ready), 8'(e_dir));
    chk({tag, " fgo"}, 8'(fgo), 8'(e_fgo));
    chk({tag, " dev_out_valid"}, 8'(dev_out_valid), 8'(e_dov));
    if (e_dov) chk({tag, " dev_out_data"}, dev_out_data, e_dod);
    chk({tag, " out_overrun"}, 8'(out_overrun), 8'(e_ovr));
    chk({tag, " int_req"}, 8'(int_req), 8'(e_int));
  endtask

  task automatic idle_inputs();
    dev_in_valid  = 1'b0;
    dev_in_data   = 8'h00;
    inp_ack       = 1'b0;
    out_strobe    = 1'b0;
    outr_data     = 8'h00;
    dev_out_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge myclock);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Reference model state (abstract: a queue plus the flag/register values)
  logic [7:0] m_q [$];
  logic [7:0] m_inpr, m_dod;
  logic       m_fgi, m_dov, m_ovr;

  initial begin
    reset = 1'b1;
    ien   = 1'b1;
    idle_inputs();

    //            div did    ack stb outr  rdy ie | fgi inpr  dir fgo dov dod   ovr int
    tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};

    // Reset values while reset is held and after release
    step();
    chk_all("in_reset", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    do_reset();
    chk_all("after_reset", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    $display("reset release: fgo=%0b fgi=%0b dev_in_ready=%0b int_req=%0b", fgo, fgi, dev_in_ready, int_req);

    // Table-driven directed cycles
    for (int i = 0; i < 9; i++) begin
      dev_in_valid  = tbl[i].div;
      dev_in_data   = tbl[i].did;
      inp_ack       = tbl[i].ack;
      out_strobe    = tbl[i].stb;
      outr_data     = tbl[i].outr;
      dev_out_ready = tbl[i].rdy;
      ien           = tbl[i].ie;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_fgi, tbl[i].e_inpr, tbl[i].e_dir, tbl[i].e_fgo,
              tbl[i].e_dov, tbl[i].e_dod, tbl[i].e_ovr, tbl[i].e_int);
      $display("vec%0d: fgi=%0b inpr=%02h fgo=%0b dov=%0b dod=%02h ovr=%0b int=%0b",
               i, fgi, inpr_data, fgo, dev_out_valid, dev_out_data, out_overrun, int_req);
    end
    idle_inputs();
    ien = 1'b1;

    // FIFO fill: five back-to-back pushes, no acks
    do_reset();
    for (int b = 1; b <= 5; b++) begin
      dev_in_valid = 1'b1;
      dev_in_data  = 8'(b);
      step();
      $display("push %02h: dev_in_ready=%0b fgi=%0b inpr=%02h", b, dev_in_ready, fgi, inpr_data);
    end
    dev_in_valid = 1'b1;
    dev_in_data  = 8'h66;   // offered while not ready: must be ignored
    step();
    dev_in_valid = 1'b0;
    chk("fill inpr_data", inpr_data, 8'h01);
    chk("fill fgi", 8'(fgi), 8'h01);
    chk("fill dev_in_ready", 8'(dev_in_ready), 8'h00);
    for (int b = 2; b <= 5; b++) begin
      inp_ack = 1'b1;
      step();
      inp_ack = 1'b0;
      chk($sformatf("drain%0d fgi_clear", b), 8'(fgi), 8'h00);
      step();
      chk($sformatf("drain%0d fgi", b), 8'(fgi), 8'h01);
      chk($sformatf("drain%0d inpr_data", b), inpr_data, 8'(b));
      $display("ack: delivered %02h", inpr_data);
    end
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;
    step();
    chk("drained fgi", 8'(fgi), 8'h00);
    chk("drained dev_in_ready", 8'(dev_in_ready), 8'h01);

    // Async reset with fgi=1, dev_out_valid=1 and a byte left in the FIFO
    dev_in_valid = 1'b1;
    dev_in_data  = 8'h77;
    out_strobe   = 1'b1;
    outr_data    = 8'h99;
    step();
    dev_in_data  = 8'h78;
    out_strobe   = 1'b0;
    step();
    dev_in_valid = 1'b0;
    chk("pre_reset fgi", 8'(fgi), 8'h01);
    chk("pre_reset dev_out_valid", 8'(dev_out_valid), 8'h01);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("async_reset dev_out_data", dev_out_data, 8'h00);
    $display("async reset: fgi=%0b dov=%0b fgo=%0b inpr=%02h", fgi, dev_out_valid, fgo, inpr_data);
    step();
    reset = 1'b0;
    step();
    step();
    chk("post_reset fgi stays 0", 8'(fgi), 8'h00);

    // Random traffic against the reference model
    do_reset();
    m_q.delete();
    m_inpr = 8'h00; m_dod = 8'h00;
    m_fgi = 1'b0; m_dov = 1'b0; m_ovr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic do_push, do_pop;
      dev_in_valid  = ($urandom_range(0, 1) == 1);
      dev_in_data   = 8'($urandom);
      inp_ack       = ($urandom_range(0, 3) == 0);
      out_strobe    = ($urandom_range(0, 6) == 0);
      outr_data     = 8'($urandom);
      dev_out_ready = ($urandom_range(0, 4) < 2);
      ien           = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd dev_in_ready", 8'(dev_in_ready), 8'(m_q.size() < DEPTH));
      chk("rnd int_req", 8'(int_req), 8'(ien && (m_fgi || !m_dov)));
      do_push = dev_in_valid && (m_q.size() < DEPTH);
      do_pop  = !m_fgi && (m_q.size() > 0);
      step();
      if (do_pop) begin
        m_inpr = m_q.pop_front();
        m_fgi  = 1'b1;
      end else if (m_fgi && inp_ack) begin
        m_fgi = 1'b0;
      end
      if (do_push) m_q.push_back(dev_in_data);
      if (!m_dov) begin
        if (out_strobe) begin
          m_dod = outr_data;
          m_dov = 1'b1;
        end
      end else begin
        if (out_strobe) m_ovr = 1'b1;
        if (dev_out_ready) m_dov = 1'b0;
      end
      chk_all("rnd", m_fgi, m_inpr, 1'(m_q.size() < DEPTH), !m_dov, m_dov, m_dod, m_ovr,
              ien && (m_fgi || !m_dov));
    end
    $display("random phase: 3000 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_handshake_unit.md
IO_HANDSHAKE_UNIT -- requirements
Module: io_handshake_unit

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the input byte FIFO (power of two, minimum 2).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset:
- myclock  in  1  sole clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high
REQ-003 The block SHALL have these ports:
- dev_in_valid  in  1  external device offers a byte
- dev_in_data  in  8  offered byte
- dev_in_ready  out  1  FIFO can accept a byte
- inpr_data  out  8  byte presented to the computer's INPR
- fgi  out  1  input flag: inpr_data holds an unread byte
- inp_ack  in  1  one-cycle pulse; INP executed, INPR consumed
- outr_data  in  8  OUTR contents
- out_strobe  in  1  one-cycle pulse; OUT executed, OUTR freshly loaded
- fgo  out  1  output flag: device free for the next byte
- dev_out_valid  out  1  byte offered to the external device
- dev_out_data  out  8  offered byte
- dev_out_ready  in  1  device accepts the byte
- ien  in  1  interrupt enable from the IEN flip-flop
- int_req  out  1  interrupt request
- out_overrun  out  1  sticky error flag

Function
REQ-004 dev_in_ready SHALL equal "FIFO count < FIFO_DEPTH" (combinational, from registered count only).
REQ-005 A push SHALL occur on an edge where dev_in_valid=1 and dev_in_ready=1; when dev_in_ready=0, dev_in_data SHALL be ignored and nothing is lost or overwritten.
REQ-006 The read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH; a push and a pop on the same edge SHALL leave count unchanged.
REQ-007 The input path SHALL have two states:
- IN_EMPTY: fgi=0
- IN_FULL: fgi=1
REQ-008 In IN_EMPTY with count>0, the next edge SHALL pop the head into inpr_data, set fgi=1, and move to IN_FULL.
REQ-009 A byte pushed into an empty FIFO at edge N SHALL appear on inpr_data with fgi=1 after edge N+1.
REQ-010 In IN_FULL, inp_ack=1 SHALL clear fgi at the next edge and return to IN_EMPTY; inpr_data SHALL hold its value.
REQ-011 The pop condition SHALL use registered fgi, so consecutive bytes reach INPR no faster than one per two cycles.
REQ-012 inp_ack while fgi=0 SHALL be ignored.
REQ-013 The output path SHALL have two states:
- OUT_IDLE: fgo=1, dev_out_valid=0
- OUT_SEND: fgo=0, dev_out_valid=1
REQ-014 In OUT_IDLE, out_strobe=1 SHALL, at the next edge, capture outr_data into dev_out_data, clear fgo, assert dev_out_valid, and move to OUT_SEND.
REQ-015 In OUT_SEND, dev_out_data SHALL stay stable until dev_out_ready=1.
REQ-016 On the edge where dev_out_ready=1 in OUT_SEND, the block SHALL deassert dev_out_valid, set fgo=1, and return to OUT_IDLE; dev_out_ready outside OUT_SEND SHALL be ignored.
REQ-017 out_strobe in OUT_SEND SHALL be ignored for data (the byte in flight is kept) and SHALL set out_overrun=1, which stays set until reset.
REQ-018 int_req SHALL be combinational: ien AND (fgi OR fgo).
REQ-019 The input and output paths SHALL be independent; simultaneous push, pop, inp_ack, out_strobe and dev_out_ready on one edge SHALL each take effect as specified above.

Reset
REQ-020 While reset=1, asynchronously:
- FIFO empty (pointers and count 0), dev_in_ready=1
- inpr_data=0x00, fgi=0, IN_EMPTY
- dev_out_data=0x00, dev_out_valid=0, fgo=1, OUT_IDLE
- out_overrun=0
REQ-021 Reset mid-transfer SHALL discard any byte in flight or in the FIFO without asserting fgi or raising any flag.

Structure
REQ-022 A shared package SHALL hold the state encodings for both paths, the byte width (8) and the FIFO_DEPTH default.
REQ-023 The FIFO SHALL be a separate sub-module, io_byte_fifo (push/pop/full/empty/count); the two FSMs and the flags SHALL live in io_handshake_unit.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset release, no stimulus -> fgo=1, fgi=0, dev_in_ready=1; with ien=1, int_req=1.
- Push 0x41 at edge N -> inpr_data=0x41, fgi=1 after edge N+1; inp_ack -> fgi=0 after the next edge.
- Push 0x01..0x05 with FIFO_DEPTH=4 and no inp_ack -> 0x01 in INPR, 0x02..0x05 in the FIFO, dev_in_ready=0; then ack each byte -> bytes 0x02..0x05 delivered in order, no loss.
- out_strobe with outr_data=0x5A, dev_out_ready held 0 for 3 cycles then 1 -> dev_out_valid high with data 0x5A throughout, fgo=0 during the wait, fgo=1 after the accept edge.
- Second out_strobe (0x33) during OUT_SEND -> out_overrun=1, device still receives 0x5A only.
- Reset asserted while fgi=1 and dev_out_valid=1 -> all outputs return to their reset values immediately, without waiting for a clock edge.
